// File: rtl/serial_add_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_add_pkg
//  Purpose  : Shared types and constants for the bit-serial add/subtract
//             engine: FSM state encoding, default operand width and the
//             bit-counter width helper.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bits needed to count 0..w-1.
  function automatic int cnt_width(input int w);
    return $clog2(w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_add_ctrl_full_add.sv
`default_nettype none
// ============================================================================
//  Module   : full_add
//  Purpose  : Single-bit full adder cell, the only arithmetic element of the
//             serial engine.
//  Ports    : a, b, cin  - addend bits and carry-in
//             sum, cout  - sum bit and carry-out
//  Revision : 1.0  initial release
// ============================================================================
module full_add (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : serial_add_ctrl
//  Purpose  : Bit-serial add/subtract engine. Operands are accepted on a
//             valid/ready handshake, processed LSB first through one full
//             adder cell over WIDTH cycles, and the result is offered on a
//             valid/ready handshake.
//  Ports    : clk, rst_n            - clock, async active-low reset
//             in_valid / in_ready   - operand handshake
//             a, b, cin, sub        - operands, carry-in, subtract select
//             out_valid / out_ready - result handshake
//             sum, cout, ovf        - result, carry-out, signed overflow
//             busy                  - high while bits are being processed
//  Revision : 1.0  initial release
// ============================================================================
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, b_sh_q, sum_sh_q;
  logic               carry_q;
  logic [CNT_W-1:0]   bit_cnt_q;
  logic [WIDTH-1:0]   sum_q;
  logic               cout_q, ovf_q;

  logic               w_fa_sum, w_fa_cout;
  logic               w_accept, w_last;

  full_add u_full_add (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .sum  (w_fa_sum),
    .cout (w_fa_cout)
  );

  assign w_accept = in_valid && (state_q == IDLE);
  assign w_last   = (state_q == RUN) && (bit_cnt_q == C_LAST_BIT);

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (w_last)    state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // ---------------- output logic ----------------
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q == RUN);
  end

  // ---------------- datapath ----------------
  // Subtraction is A + ~B + 1, so the inversion and forced carry are applied
  // at load time and the serial loop is identical for both operations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      sum_sh_q  <= '0;
      carry_q   <= 1'b0;
      bit_cnt_q <= '0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      if (w_accept) begin
        a_sh_q    <= a;
        b_sh_q    <= sub ? ~b : b;
        carry_q   <= sub ? 1'b1 : cin;
        bit_cnt_q <= '0;
      end else if (state_q == RUN) begin
        a_sh_q    <= {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_q    <= {1'b0, b_sh_q[WIDTH-1:1]};
        sum_sh_q  <= {w_fa_sum, sum_sh_q[WIDTH-1:1]};
        carry_q   <= w_fa_cout;
        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
        // On the MSB, carry_q is the carry into the MSB, so XOR with the
        // cell carry-out gives two's-complement overflow.
        if (w_last) begin
          sum_q  <= {w_fa_sum, sum_sh_q[WIDTH-1:1]};
          cout_q <= w_fa_cout;
          ovf_q  <= carry_q ^ w_fa_cout;
        end
      end
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_add_ctrl
//  Purpose  : Directed self-checking bench for serial_add_ctrl (WIDTH=8).
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             sub = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  int total = 0;
  int bad   = 0;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v)
    else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands, hold them for the acceptance edge, then wait for the
  // result with a bounded loop and check latency and result values.
  task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic ci, input logic sb,
                        input logic [7:0] exp_sum, input logic exp_cout, input logic exp_ovf);
    int n;
    a = av; b = bv; cin = ci; sub = sb; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, ".busy"}, {31'd0, busy}, 32'd1);
    check({tag, ".in_ready_run"}, {31'd0, in_ready}, 32'd0);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, ".latency"}, n, 32'd8);
    check({tag, ".sum"}, {24'd0, sum}, {24'd0, exp_sum});
    check({tag, ".cout"}, {31'd0, cout}, {31'd0, exp_cout});
    check({tag, ".ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, ".out_valid_after_hs"}, {31'd0, out_valid}, 32'd0);
    check({tag, ".in_ready_after_hs"}, {31'd0, in_ready}, 32'd1);
  endtask

  logic [7:0] q_a   [3];
  logic [7:0] q_b   [3];
  logic       q_sub [3];
  logic [7:0] q_sum [3];
  logic       q_co  [3];
  logic       q_ov  [3];

  initial begin
    int idx, ri, cyc, last_acc;
    logic acc;

    // ---- reset values ----
    repeat (2) @(posedge clk);
    #1;
    check("rst.in_ready", {31'd0, in_ready}, 32'd1);
    check("rst.out_valid", {31'd0, out_valid}, 32'd0);
    check("rst.busy", {31'd0, busy}, 32'd0);
    check("rst.sum", {24'd0, sum}, 32'd0);
    check("rst.cout", {31'd0, cout}, 32'd0);
    check("rst.ovf", {31'd0, ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ---- add with overflow, out_valid held until out_ready ----
    run_op("add", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1);
    tick();
    check("add.hold_valid", {31'd0, out_valid}, 32'd1);
    handshake("add");

    // ---- wrap cases ----
    run_op("wrap1", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    handshake("wrap1");
    run_op("wrap2", 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    handshake("wrap2");

    // ---- subtract; cin=1 must be ignored ----
    run_op("sub1", 8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0);
    handshake("sub1");
    run_op("sub2", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

    // ---- backpressure: 5 cycles with out_ready low ----
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp.out_valid", {31'd0, out_valid}, 32'd1);
      check("bp.in_ready", {31'd0, in_ready}, 32'd0);
      check("bp.sum", {24'd0, sum}, 32'h7F);
      check("bp.cout", {31'd0, cout}, 32'd1);
      check("bp.ovf", {31'd0, ovf}, 32'd1);
    end
    handshake("bp");

    // ---- in_valid pulsed during RUN is ignored ----
    a = 8'h33; b = 8'h11; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    a = 8'hAA; b = 8'hAA; cin = 1'b1; sub = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    check("ign.latency_rest", cyc, 32'd5);
    check("ign.sum", {24'd0, sum}, 32'h44);
    check("ign.cout", {31'd0, cout}, 32'd0);
    check("ign.ovf", {31'd0, ovf}, 32'd0);
    handshake("ign");
    repeat (12) tick();
    check("ign.no_second", {31'd0, out_valid}, 32'd0);
    check("ign.idle", {31'd0, in_ready}, 32'd1);

    // ---- reset during the 3rd RUN cycle ----
    a = 8'h01; b = 8'h02; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst.out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst.sum", {24'd0, sum}, 32'd0);
    check("mid_rst.in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst.busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_op("post_rst", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0);
    handshake("post_rst");

    // ---- throughput with in_valid / out_ready held high ----
    q_a[0] = 8'h01; q_b[0] = 8'h02; q_sub[0] = 1'b0; q_sum[0] = 8'h03; q_co[0] = 1'b0; q_ov[0] = 1'b0;
    q_a[1] = 8'h7F; q_b[1] = 8'h01; q_sub[1] = 1'b0; q_sum[1] = 8'h80; q_co[1] = 1'b0; q_ov[1] = 1'b1;
    q_a[2] = 8'h20; q_b[2] = 8'h05; q_sub[2] = 1'b1; q_sum[2] = 8'h1B; q_co[2] = 1'b1; q_ov[2] = 1'b0;
    idx = 0; ri = 0; cyc = 0; last_acc = -1;
    a = q_a[0]; b = q_b[0]; sub = q_sub[0]; cin = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    while (ri < 3 && cyc < 60) begin
      acc = in_ready && in_valid;
      if (out_valid) begin
        check("tp.sum", {24'd0, sum}, {24'd0, q_sum[ri]});
        check("tp.cout", {31'd0, cout}, {31'd0, q_co[ri]});
        check("tp.ovf", {31'd0, ovf}, {31'd0, q_ov[ri]});
        ri++;
      end
      tick();
      cyc++;
      if (acc) begin
        if (last_acc >= 0) check("tp.interval", cyc - last_acc, 32'd10);
        last_acc = cyc;
        idx++;
        if (idx < 3) begin
          a = q_a[idx]; b = q_b[idx]; sub = q_sub[idx];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    check("tp.results", ri, 32'd3);
    check("tp.accepts", idx, 32'd3);
    out_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial add/subtract engine that time-shares a single 1-bit full adder cell across WIDTH cycles to add or subtract two WIDTH-bit operands. Operands are accepted on a valid/ready input handshake, processed LSB first, and the result is presented on a valid/ready output handshake. It is the sequencing layer above the team's full-adder cell: it owns the operand shift registers, the carry flop, the bit counter and the control FSM.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand request
- in_ready  out  1  block can accept operands
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in for add; ignored when sub=1
- sub  in  1  1 = compute A−B (B inverted, carry-in forced to 1)
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result
- cout  out  1  carry-out (for sub: 1 = no borrow)
- ovf  out  1  two's-complement overflow
- busy  out  1  high in RUN

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready, capture a_sh<=a, b_sh<=(sub ? ~b : b), carry<=(sub ? 1 : cin), bit_cnt<=0, then go to RUN.
- RUN:
  - The full-adder cell is fed a_sh[0], b_sh[0] and carry.
  - Each cycle: a_sh and b_sh shift right by one; the sum bit shifts into the MSB of sum_sh; carry<=cell cout; bit_cnt++.
  - On the cycle with bit_cnt==WIDTH−1, latch ovf<=carry ^ cell cout (carry into MSB XOR carry out of MSB), then go to DONE.
- DONE:
  - out_valid=1. sum, cout and ovf are held stable.
  - On out_ready, go to IDLE.
- in_ready=0 in RUN and DONE. in_valid is ignored there; no request is queued.
- sum, cout and ovf are registered and change only on the RUN→DONE transition.
- Reset values: in_ready=1, out_valid=0, busy=0, sum=0, cout=0, ovf=0. All internal registers are 0.
- Reset asserted mid-RUN or in DONE: the operation is aborted, outputs return to reset values immediately (asynchronous), and no result is produced.
- Arithmetic: sum = (A + B' + c0) mod 2^WIDTH; cout = bit WIDTH of that sum. Here B' and c0 are b and cin for add, and ~b and 1 for sub.

## Timing
- Acceptance at clock edge E0.
- Bits 0..WIDTH−1 are processed on edges E1..EWIDTH.
- out_valid rises after edge EWIDTH: latency is WIDTH cycles from acceptance.
- The earliest out_ready handshake is at edge EWIDTH+1. in_ready rises the same cycle.
- Back-to-back throughput is one operation per WIDTH+2 cycles: accept, WIDTH bits, one output handshake cycle.
- out_ready held high in advance gives a 1-cycle DONE.
- out_valid, once high, stays high until the handshake; holding out_ready low for any number of cycles preserves the outputs.

## Structure
- Shared package serial_add_pkg:
  - state encoding typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - default width constant;
  - counter width = $clog2(WIDTH).
- One sub-module instance: full_add (a, b, cin, sum, cout) as the per-bit datapath. There is no other arithmetic in the block.

## Test plan
All scenarios use WIDTH=8.
- Add: a=0x5A, b=0x3C, cin=0, sub=0 → after 8 cycles sum=0x96, cout=0, ovf=1; out_valid held until out_ready.
- Wrap: a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, ovf=0. Also a=0xFF, b=0x00, cin=1 → sum=0x00, cout=1.
- Subtract: a=0x10, b=0x20, sub=1 → sum=0xF0, cout=0, ovf=0. Also a=0x80, b=0x01, sub=1 → sum=0x7F, cout=1, ovf=1.
- Backpressure and ignore:
  - Hold out_ready low for 5 cycles in DONE → sum, cout, ovf, out_valid stable; in_ready stays 0.
  - Pulse in_valid during RUN → no effect on the result and no second result.
- Reset mid-operation: assert rst_n=0 on the 3rd RUN cycle → out_valid=0, sum=0, in_ready=1 immediately. Next request 0x01+0x01 → sum=0x02 with normal 8-cycle latency.
- Throughput: in_valid and out_ready held high with 3 queued operands → in_ready pulses every 10 cycles; results are in order and correct.
